// File: rtl/seg7_scan_ctrl.sv
// Multiplexed 7-segment scan driver with double-buffered
// digit data, per-digit enable, decimal point and blink.
module seg7_scan_ctrl #(
  parameter int NUM_DIGITS   = 8,
  parameter int DIV          = 1,
  parameter int BLINK_FRAMES = 64,
  parameter int HEX_MODE     = 0
) (
  input  logic                    ck,
  input  logic                    rst_n,
  input  logic [4*NUM_DIGITS-1:0] digit_val,
  input  logic [NUM_DIGITS-1:0]   digit_en,
  input  logic [NUM_DIGITS-1:0]   dp,
  input  logic [NUM_DIGITS-1:0]   blink_mask,
  input  logic                    load,
  output logic [7:0]              seg,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_done,
  output logic                    pending,
  output logic                    blink_phase
);

  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_DIGITS - 1);
  localparam logic [PW-1:0] LAST_PS  = PW'(DIV - 1);
  localparam logic [FW-1:0] LAST_FR  = FW'(BLINK_FRAMES - 1);
  localparam logic [NUM_DIGITS-1:0] ONE = NUM_DIGITS'(1);

  logic [PW-1:0] presc_q, presc_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [FW-1:0] fcnt_q, fcnt_d;
  logic          blink_q, blink_d;
  logic          pend_q, pend_d;
  logic          fdone_q;
  logic [7:0]    seg_q, seg_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;

  logic [4*NUM_DIGITS-1:0] act_val_q, act_val_d;
  logic [NUM_DIGITS-1:0]   act_en_q, act_en_d;
  logic [NUM_DIGITS-1:0]   act_dp_q, act_dp_d;
  logic [NUM_DIGITS-1:0]   act_bm_q, act_bm_d;
  logic [4*NUM_DIGITS-1:0] pnd_val_q, pnd_val_d;
  logic [NUM_DIGITS-1:0]   pnd_en_q, pnd_en_d;
  logic [NUM_DIGITS-1:0]   pnd_dp_q, pnd_dp_d;
  logic [NUM_DIGITS-1:0]   pnd_bm_q, pnd_bm_d;

  logic       tick;
  logic       wrap;
  logic       lit;
  logic [3:0] code;

  // Active-low glyphs; codes above 9 depend on HEX_MODE.
  function automatic logic [6:0] glyph(input logic [3:0] c);
    logic [6:0] g;
    g = 7'h7F;
    unique case (c)
      4'h0: g = 7'h40;
      4'h1: g = 7'h79;
      4'h2: g = 7'h24;
      4'h3: g = 7'h30;
      4'h4: g = 7'h19;
      4'h5: g = 7'h12;
      4'h6: g = 7'h02;
      4'h7: g = 7'h78;
      4'h8: g = 7'h00;
      4'h9: g = 7'h10;
      4'hA: g = (HEX_MODE != 0) ? 7'h08 : 7'h7F;
      4'hB: g = (HEX_MODE != 0) ? 7'h03 : 7'h7F;
      4'hC: g = (HEX_MODE != 0) ? 7'h46 : 7'h7F;
      4'hD: g = (HEX_MODE != 0) ? 7'h21 : 7'h7F;
      4'hE: g = (HEX_MODE != 0) ? 7'h06 : 7'h7F;
      4'hF: g = (HEX_MODE != 0) ? 7'h0E : 7'h7F;
      default: g = 7'h7F;
    endcase
    return g;
  endfunction

  assign tick = (presc_q == LAST_PS);
  assign wrap = tick && (idx_q == LAST_IDX);

  // Scan position, frame/blink counters and buffer hand-over.
  always_comb begin
    presc_d   = tick ? '0 : presc_q + 1'b1;
    idx_d     = idx_q;
    fcnt_d    = fcnt_q;
    blink_d   = blink_q;
    pend_d    = pend_q;
    act_val_d = act_val_q;
    act_en_d  = act_en_q;
    act_dp_d  = act_dp_q;
    act_bm_d  = act_bm_q;
    pnd_val_d = pnd_val_q;
    pnd_en_d  = pnd_en_q;
    pnd_dp_d  = pnd_dp_q;
    pnd_bm_d  = pnd_bm_q;
    if (tick) begin
      idx_d = (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;
    end
    if (wrap) begin
      if (fcnt_q == LAST_FR) begin
        fcnt_d  = '0;
        blink_d = ~blink_q;
      end else begin
        fcnt_d = fcnt_q + 1'b1;
      end
      if (load) begin
        act_val_d = digit_val;
        act_en_d  = digit_en;
        act_dp_d  = dp;
        act_bm_d  = blink_mask;
        pend_d    = 1'b0;
      end else if (pend_q) begin
        act_val_d = pnd_val_q;
        act_en_d  = pnd_en_q;
        act_dp_d  = pnd_dp_q;
        act_bm_d  = pnd_bm_q;
        pend_d    = 1'b0;
      end
    end else if (load) begin
      pnd_val_d = digit_val;
      pnd_en_d  = digit_en;
      pnd_dp_d  = dp;
      pnd_bm_d  = blink_mask;
      pend_d    = 1'b1;
    end
  end

  // Outputs follow the post-edge digit and data, so the
  // first slot of a frame already shows the new buffer.
  always_comb begin
    lit  = act_en_d[idx_d] && !(blink_d && act_bm_d[idx_d]);
    code = act_val_d[{idx_d, 2'b00} +: 4];
    seg_d = 8'hFF;
    an_d  = '1;
    if (lit) begin
      seg_d = {~act_dp_d[idx_d], glyph(code)};
      an_d  = ~(ONE << idx_d);
    end
  end

  // State registers.
  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n) begin
      presc_q   <= '0;
      idx_q     <= '0;
      fcnt_q    <= '0;
      blink_q   <= 1'b0;
      pend_q    <= 1'b0;
      fdone_q   <= 1'b0;
      seg_q     <= 8'hFF;
      an_q      <= '1;
      act_val_q <= '0;
      act_en_q  <= '0;
      act_dp_q  <= '0;
      act_bm_q  <= '0;
      pnd_val_q <= '0;
      pnd_en_q  <= '0;
      pnd_dp_q  <= '0;
      pnd_bm_q  <= '0;
    end else begin
      presc_q   <= presc_d;
      idx_q     <= idx_d;
      fcnt_q    <= fcnt_d;
      blink_q   <= blink_d;
      pend_q    <= pend_d;
      fdone_q   <= wrap;
      seg_q     <= seg_d;
      an_q      <= an_d;
      act_val_q <= act_val_d;
      act_en_q  <= act_en_d;
      act_dp_q  <= act_dp_d;
      act_bm_q  <= act_bm_d;
      pnd_val_q <= pnd_val_d;
      pnd_en_q  <= pnd_en_d;
      pnd_dp_q  <= pnd_dp_d;
      pnd_bm_q  <= pnd_bm_d;
    end
  end

  assign seg         = seg_q;
  assign an          = an_q;
  assign frame_done  = fdone_q;
  assign pending     = pend_q;
  assign blink_phase = blink_q;

endmodule
